key_event_ctrl: RTL
===================

// Module: key_event_ctrl
// PURPOSE
//  Upstream key conditioning for the 7-seg setter: turns one raw mechanical key into clean,
//  single-cycle events. Feeds the load/select/digit-increment inputs of the display counter
//  logic, replacing bare debounce-plus-edge usage. Adds press, release, long-press and optional
//  auto-repeat events. Instantiate one per key.
// PARAMETERS
//  DEBOUNCE_CYC  1_000_000   stable cycles needed to accept a level change (20 ms @ 50 MHz); >=2
//  LONG_CYC      50_000_000  held cycles, counted from press_pulse, to raise long_pulse (1 s); >DEBOUNCE_CYC
//  REPEAT_CYC    10_000_000  auto-repeat period after long press (200 ms); >=2
//  CNT_W         26          counter width; must hold max(DEBOUNCE_CYC,LONG_CYC,REPEAT_CYC)
// PORTS
//  clk            in   1  system clock
//  rst_n          in   1  asynchronous active-low reset
//  key_in         in   1  raw key, active-low, asynchronous to clk
//  key_level      out  1  debounced level, active-low (1 = released)
//  key_held       out  1  1 while debounced pressed (= ~key_level)
//  press_pulse    out  1  one-cycle pulse on accepted press
//  release_pulse  out  1  one-cycle pulse on accepted release
//  long_pulse     out  1  one-cycle pulse when hold reaches LONG_CYC
//  repeat_pulse   out  1  one-cycle auto-repeat pulse (macro-dependent)
// BEHAVIOUR
//  - Reset: sync FFs=1, FSM=IDLE, all counters 0, key_level=1, key_held=0, all pulses 0.
//  - key_in through 2-FF synchronizer -> ks. All outputs registered.
//  - FSM IDLE -> PRESS_DB -> HELD -> RELEASE_DB -> IDLE; db_cnt and hold_cnt are separate.
//  - IDLE: ks=0 -> PRESS_DB, db_cnt<=0.
//  - PRESS_DB: ks=1 -> IDLE (bounce, no event); ks=0 & db_cnt==DEBOUNCE_CYC-1 -> HELD,
//    key_level<=0, press_pulse<=1, hold_cnt<=0; else db_cnt++.
//  - Latency: if edge k first samples key_in=0 and it stays low, press_pulse is high
//    in the cycle after edge k+DEBOUNCE_CYC+2. Release is symmetric.
//  - HELD: ks=1 -> RELEASE_DB, db_cnt<=0. hold_cnt++ each cycle in HELD and RELEASE_DB,
//    saturating at LONG_CYC.
//  - long_pulse is high for exactly one cycle when hold_cnt reaches LONG_CYC-1.
//    Fires at most once per press. If release completes first, long_pulse never fires.
//  - RELEASE_DB: ks=0 -> HELD (bounce, no event, hold_cnt keeps its value);
//    ks=1 & db_cnt==DEBOUNCE_CYC-1 -> IDLE, key_level<=1, release_pulse<=1; else db_cnt++.
//  - Pulses never coincide. press/release strictly alternate after reset.
//  - rst_n low in any state: outputs return to reset values at once. No release_pulse is
//    emitted for the aborted press.
// CONFIGURATION
//  KEY_REPEAT_EN defined:
//   - After long_pulse, repeat_pulse fires every REPEAT_CYC cycles while in HELD.
//     First fire is REPEAT_CYC cycles after long_pulse.
//   - rpt_cnt freezes in RELEASE_DB and resumes on return to HELD.
//   - rpt_cnt clears in IDLE.
//  KEY_REPEAT_EN undefined: repeat_pulse tied 0; rpt_cnt not built.
// TESTING  (DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=5, CNT_W=8)
//  1 Reset with key_in=1, then with key_in=0 -> key_level=1, key_held=0, all pulses 0 during reset.
//  2 key_in low at edge 10, held 30 cycles, then high:
//      press_pulse single cycle after edge 16; key_level=0 from then;
//      release_pulse single cycle 6 edges after key_in rises; key_level=1.
//  3 key_in low 3 cycles then high -> no pulses, key_level stays 1.
//    Repeat for release: high 3 cycles mid-hold -> no release_pulse.
//  4 Hold 60 cycles -> long_pulse exactly once, 20 cycles after press_pulse.
//      With KEY_REPEAT_EN: repeat_pulse at +5, +10, +15 ... after long_pulse.
//      Without KEY_REPEAT_EN: repeat_pulse always 0.
//  5 Release bounce (key_in high 2 cycles) at hold_cnt=10 -> no release event;
//    long_pulse still fires at hold_cnt=19.
//  6 rst_n low 2 cycles while HELD -> outputs idle immediately; no release_pulse afterwards;
//    fresh press behaves as in test 2.

Source files
------------

// File: rtl/key_event_ctrl.sv
// key_event_ctrl
//   Conditions one raw mechanical key (active-low, asynchronous to clk) into
//   a debounced level plus single-cycle press, release, long-press and
//   optional auto-repeat events. Instantiate one per key.
//
//   Build option: define KEY_REPEAT_EN to build the auto-repeat counter.
//   Without it, repeat_pulse is tied to 0.
//
//   Ports
//     clk            in   system clock
//     rst_n          in   asynchronous active-low reset
//     key_in         in   raw key, active-low
//     key_level      out  debounced level, active-low (1 = released)
//     key_held       out  1 while debounced pressed
//     press_pulse    out  one-cycle pulse on accepted press
//     release_pulse  out  one-cycle pulse on accepted release
//     long_pulse     out  one-cycle pulse when the hold reaches LONG_CYC
//     repeat_pulse   out  one-cycle auto-repeat pulse (KEY_REPEAT_EN only)
//     dbg_state      out  current FSM state (S_IDLE..S_RELEASE_DB)
//
//   Handshake: none; every output is a registered level or pulse that is
//   valid in the cycle after the clock edge producing it.
module key_event_ctrl #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000,
    parameter int REPEAT_CYC   = 10_000_000,
    parameter int CNT_W        = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_in,
    output logic       key_level,
    output logic       key_held,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_PRESS_DB   = 2'd1,
        S_HELD       = 2'd2,
        S_RELEASE_DB = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYC);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_sync1;
    logic               r_sync2;
    logic [CNT_W-1:0]   r_db_cnt;
    logic [CNT_W-1:0]   w_db_cnt_next;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic               r_key_level;
    logic               r_key_held;
    logic               r_press;
    logic               r_release;
    logic               r_long;
    logic               w_ks;
    logic               w_db_last;
    logic               w_press_set;
    logic               w_release_set;
    logic               w_in_hold;
    logic               w_long_set;

    assign w_ks      = r_sync2;
    assign w_db_last = (r_db_cnt == DB_LAST);
    // hold_cnt runs through both pressed states so a release bounce does
    // not restart the long-press timer.
    assign w_in_hold = (r_state == S_HELD) || (r_state == S_RELEASE_DB);
    // A release completing on the same edge wins over the long press.
    assign w_long_set = w_in_hold && (r_hold_cnt == LONG_LAST) && !w_release_set;

    always_comb begin
        w_state_next  = r_state;
        w_db_cnt_next = r_db_cnt;
        w_press_set   = 1'b0;
        w_release_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_ks) begin
                    w_state_next  = S_PRESS_DB;
                    w_db_cnt_next = '0;
                end
            end
            S_PRESS_DB: begin
                if (w_ks) begin
                    w_state_next = S_IDLE;
                end else if (w_db_last) begin
                    w_state_next = S_HELD;
                    w_press_set  = 1'b1;
                end else begin
                    w_db_cnt_next = r_db_cnt + 1'b1;
                end
            end
            S_HELD: begin
                if (w_ks) begin
                    w_state_next  = S_RELEASE_DB;
                    w_db_cnt_next = '0;
                end
            end
            S_RELEASE_DB: begin
                if (!w_ks) begin
                    w_state_next = S_HELD;
                end else if (w_db_last) begin
                    w_state_next  = S_IDLE;
                    w_release_set = 1'b1;
                end else begin
                    w_db_cnt_next = r_db_cnt + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= S_IDLE;
            r_db_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_key_level <= 1'b1;
            r_key_held  <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_sync1   <= key_in;
            r_sync2   <= r_sync1;
            r_state   <= w_state_next;
            r_db_cnt  <= w_db_cnt_next;
            r_press   <= w_press_set;
            r_release <= w_release_set;
            r_long    <= w_long_set;
            if (w_press_set) begin
                r_key_level <= 1'b0;
                r_key_held  <= 1'b1;
            end else if (w_release_set) begin
                r_key_level <= 1'b1;
                r_key_held  <= 1'b0;
            end
            if (w_press_set) begin
                r_hold_cnt <= '0;
            end else if (w_in_hold && (r_hold_cnt != LONG_MAX)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYC - 1);

    logic [CNT_W-1:0] r_rpt_cnt;
    logic             r_repeat;
    logic             w_rpt_armed;

    // hold_cnt sits at LONG_MAX only after long_pulse has fired in this press,
    // so it doubles as the "repeat armed" flag. Counting happens in HELD only,
    // which freezes the count while a release is being debounced.
    assign w_rpt_armed = (r_state == S_HELD) && (r_hold_cnt == LONG_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rpt_cnt <= '0;
            r_repeat  <= 1'b0;
        end else begin
            r_repeat <= 1'b0;
            if (r_state == S_IDLE) begin
                r_rpt_cnt <= '0;
            end else if (w_rpt_armed) begin
                if (r_rpt_cnt == RPT_LAST) begin
                    r_rpt_cnt <= '0;
                    r_repeat  <= 1'b1;
                end else begin
                    r_rpt_cnt <= r_rpt_cnt + 1'b1;
                end
            end
        end
    end

    assign repeat_pulse = r_repeat;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign key_level     = r_key_level;
    assign key_held      = r_key_held;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_pulse    = r_long;
    assign dbg_state     = r_state;

endmodule
